// File: rtl/out_port_receiver_pkg.sv
// Shared sizing constants for the OUT-port receiver and its FIFO.
package out_port_receiver_pkg;

    localparam int unsigned OUT_FIFO_DEPTH = 4;
    localparam int unsigned OUT_DATA_WIDTH = 16;
    localparam int unsigned DROP_CNT_W     = 8;
    localparam int unsigned OUT_CNT_W      = $clog2(OUT_FIFO_DEPTH) + 1;

endpackage

// File: rtl/out_port_receiver_sync_fifo.sv
// First-word-fall-through synchronous FIFO: memory, wrapping pointers and occupancy.
module out_port_receiver_sync_fifo
    import out_port_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int unsigned DEPTH      = OUT_FIFO_DEPTH,
    parameter int unsigned CNT_W      = OUT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic [CNT_W-1:0]      count,
    output logic                  notEmpty,
    output logic                  full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W-1:0]      wrPtr;
    logic [CNT_W-1:0]      nextCount;
    logic                  doPush;
    logic                  doPop;

    // Guard against callers popping empty or pushing into a full FIFO without a pop.
    always_comb begin
        doPop     = pop && notEmpty;
        doPush    = push && (!full || doPop);
        nextCount = count;
        unique case ({doPush, doPop})
            2'b10:   nextCount = count + CNT_W'(1);
            2'b01:   nextCount = count - CNT_W'(1);
            default: nextCount = count;
        endcase
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (doPush && !reset) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            notEmpty <= 1'b0;
            full     <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count    <= nextCount;
            notEmpty <= (nextCount != '0);
            full     <= (nextCount == CNT_W'(DEPTH));
        end
    end

    assign rdData = mem[rdPtr];

endmodule

// File: rtl/out_port_receiver.sv
// Captures processor OUT-port words into a FIFO, drains them over valid/ready, and accounts for drops.
module out_port_receiver
    import out_port_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int unsigned DEPTH      = OUT_FIFO_DEPTH,
    parameter int unsigned CNT_W      = OUT_CNT_W,
    parameter int unsigned DROP_W     = DROP_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] outPortData,
    input  logic                  outSignalEn,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count,
    input  logic                  clear_overflow
);

    logic [DATA_WIDTH-1:0] headData;
    logic                  notEmpty;
    logic                  pop;
    logic                  push;
    logic                  drop;

    always_comb begin
        pop  = notEmpty && m_ready;
        push = outSignalEn && (!full || pop);
        drop = outSignalEn && full && !pop;
    end

    out_port_receiver_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wrData  (outPortData),
        .rdData  (headData),
        .count   (count),
        .notEmpty(notEmpty),
        .full    (full)
    );

    // A drop in the same cycle as a clear wins, so the counter restarts at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= DROP_W'(1);
            end else if (!(&drop_count)) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    // Head word is masked while empty so stale memory never leaks out.
    assign m_valid = notEmpty;
    assign m_data  = notEmpty ? headData : '0;

endmodule

// File: tb/tb_out_port_receiver.sv
// Directed vector bench for out_port_receiver with a few hand-written multi-cycle sequences.
module tb_out_port_receiver;

    logic        clk;
    logic        reset;
    logic [15:0] outPortData;
    logic        outSignalEn;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clear_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [15:0] data;
        logic        rdy;
        logic        clr;
        logic        eValid;
        logic [15:0] eData;
        logic [2:0]  eCount;
        logic        eFull;
        logic        eOvf;
        logic [7:0]  eDrop;
    } vec_t;

    vec_t vq[$];

    out_port_receiver dut (
        .clk           (clk),
        .reset         (reset),
        .outPortData   (outPortData),
        .outSignalEn   (outSignalEn),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .clear_overflow(clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [15:0] d,
                        input logic rd, input logic c);
        reset          = r;
        outSignalEn    = e;
        outPortData    = d;
        m_ready        = rd;
        clear_overflow = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic [15:0] d, input logic rd,
                       input logic c, input logic v, input logic [15:0] ed, input logic [2:0] ec,
                       input logic ef, input logic eo, input logic [7:0] edr);
        vec_t t;
        t = '{rst: r, en: e, data: d, rdy: rd, clr: c, eValid: v, eData: ed,
              eCount: ec, eFull: ef, eOvf: eo, eDrop: edr};
        vq.push_back(t);
    endtask

    initial begin
        reset = 1'b0; outSignalEn = 1'b0; outPortData = '0; m_ready = 1'b0; clear_overflow = 1'b0;
        @(posedge clk);
        #1;

        //   rst en data      rdy clr   v  data     cnt   f  ovf drop
        add(1, 1, 16'h1234, 0, 0,   0, 16'h0000, 3'd0, 0, 0, 8'd0);   // reset wins
        add(0, 1, 16'h0005, 0, 0,   1, 16'h0005, 3'd1, 0, 0, 8'd0);
        add(0, 0, 16'hxxxx, 1, 0,   0, 16'h0000, 3'd0, 0, 0, 8'd0);
        add(0, 1, 16'h0005, 0, 0,   1, 16'h0005, 3'd1, 0, 0, 8'd0);
        add(0, 1, 16'h0019, 0, 0,   1, 16'h0005, 3'd2, 0, 0, 8'd0);
        add(0, 1, 16'hFFFF, 0, 0,   1, 16'h0005, 3'd3, 0, 0, 8'd0);
        add(0, 1, 16'hF320, 0, 0,   1, 16'h0005, 3'd4, 1, 0, 8'd0);
        add(0, 1, 16'hAAAA, 0, 0,   1, 16'h0005, 3'd4, 1, 1, 8'd1);   // drops
        add(0, 1, 16'hBBBB, 0, 0,   1, 16'h0005, 3'd4, 1, 1, 8'd2);
        add(0, 0, 16'hxxxx, 0, 1,   1, 16'h0005, 3'd4, 1, 0, 8'd0);   // clear
        add(0, 0, 16'hxxxx, 1, 0,   1, 16'h0019, 3'd3, 0, 0, 8'd0);   // drain
        add(0, 0, 16'hxxxx, 1, 0,   1, 16'hFFFF, 3'd2, 0, 0, 8'd0);
        add(0, 0, 16'hxxxx, 1, 0,   1, 16'hF320, 3'd1, 0, 0, 8'd0);
        add(0, 0, 16'hxxxx, 1, 0,   0, 16'h0000, 3'd0, 0, 0, 8'd0);
        add(0, 0, 16'hxxxx, 1, 0,   0, 16'h0000, 3'd0, 0, 0, 8'd0);   // ready while empty
        add(0, 1, 16'h1111, 0, 0,   1, 16'h1111, 3'd1, 0, 0, 8'd0);
        add(0, 1, 16'h2222, 0, 0,   1, 16'h1111, 3'd2, 0, 0, 8'd0);
        add(0, 1, 16'h3333, 0, 0,   1, 16'h1111, 3'd3, 0, 0, 8'd0);
        add(0, 1, 16'h4444, 0, 0,   1, 16'h1111, 3'd4, 1, 0, 8'd0);
        add(0, 1, 16'h7777, 1, 0,   1, 16'h2222, 3'd4, 1, 0, 8'd0);   // pop-through when full
        add(0, 0, 16'hxxxx, 0, 0,   1, 16'h2222, 3'd4, 1, 0, 8'd0);   // stall holds head
        add(0, 0, 16'hxxxx, 1, 0,   1, 16'h3333, 3'd3, 0, 0, 8'd0);
        add(0, 0, 16'hxxxx, 1, 0,   1, 16'h4444, 3'd2, 0, 0, 8'd0);
        add(0, 0, 16'hxxxx, 1, 0,   1, 16'h7777, 3'd1, 0, 0, 8'd0);
        add(0, 0, 16'hxxxx, 1, 0,   0, 16'h0000, 3'd0, 0, 0, 8'd0);
        add(0, 1, 16'h0A01, 0, 0,   1, 16'h0A01, 3'd1, 0, 0, 8'd0);
        add(0, 1, 16'h0A02, 0, 0,   1, 16'h0A01, 3'd2, 0, 0, 8'd0);
        add(0, 1, 16'h0A03, 0, 0,   1, 16'h0A01, 3'd3, 0, 0, 8'd0);
        add(0, 1, 16'h0A04, 0, 0,   1, 16'h0A01, 3'd4, 1, 0, 8'd0);
        add(0, 1, 16'h0BAD, 0, 0,   1, 16'h0A01, 3'd4, 1, 1, 8'd1);
        add(0, 1, 16'h0BAD, 0, 1,   1, 16'h0A01, 3'd4, 1, 1, 8'd1);   // drop beats clear
        add(0, 1, 16'h0BAD, 0, 0,   1, 16'h0A01, 3'd4, 1, 1, 8'd2);
        add(0, 1, 16'h5555, 0, 0,   1, 16'h0A01, 3'd4, 1, 1, 8'd3);
        add(1, 1, 16'h5555, 0, 0,   0, 16'h0000, 3'd0, 0, 0, 8'd0);   // reset mid-stream
        add(0, 0, 16'hxxxx, 1, 0,   0, 16'h0000, 3'd0, 0, 0, 8'd0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].en, vq[i].data, vq[i].rdy, vq[i].clr);
            chk($sformatf("v%0d.m_valid", i),    32'(m_valid),    32'(vq[i].eValid));
            chk($sformatf("v%0d.m_data", i),     32'(m_data),     32'(vq[i].eData));
            chk($sformatf("v%0d.count", i),      32'(count),      32'(vq[i].eCount));
            chk($sformatf("v%0d.full", i),       32'(full),       32'(vq[i].eFull));
            chk($sformatf("v%0d.overflow", i),   32'(overflow),   32'(vq[i].eOvf));
            chk($sformatf("v%0d.drop_count", i), 32'(drop_count), 32'(vq[i].eDrop));
        end

        // Streaming with a ready consumer: each word appears one cycle after its push.
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 16'(i), 1, 0);
            chk($sformatf("stream%0d.m_valid", i), 32'(m_valid), 32'd1);
            chk($sformatf("stream%0d.m_data", i),  32'(m_data),  32'(i));
            chk($sformatf("stream%0d.count", i),   32'(count),   32'd1);
        end
        step(0, 0, 16'h0000, 1, 0);
        chk("stream_end.m_valid",  32'(m_valid),  32'd0);
        chk("stream_end.overflow", 32'(overflow), 32'd0);

        // Reset with three words buffered.
        for (int i = 0; i < 3; i++) step(0, 1, 16'(16'hC000 + i), 0, 0);
        chk("buf3.count",  32'(count),  32'd3);
        chk("buf3.m_data", 32'(m_data), 32'hC000);
        step(1, 0, 16'h0000, 0, 0);
        chk("buf3_rst.count",   32'(count),   32'd0);
        chk("buf3_rst.m_valid", 32'(m_valid), 32'd0);
        chk("buf3_rst.m_data",  32'(m_data),  32'd0);

        // Drop counter saturation.
        for (int i = 0; i < 4; i++) step(0, 1, 16'(16'hD000 + i), 0, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 16'hEEEE, 0, 0);
        chk("sat.drop_count", 32'(drop_count), 32'd255);
        chk("sat.overflow",   32'(overflow),   32'd1);
        chk("sat.m_data",     32'(m_data),     32'hD000);
        step(0, 0, 16'h0000, 0, 1);
        chk("sat_clr.drop_count", 32'(drop_count), 32'd0);
        chk("sat_clr.overflow",   32'(overflow),   32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sat_drain%0d.m_data", i), 32'(m_data), 32'(16'hD000 + i));
            step(0, 0, 16'h0000, 1, 0);
        end
        chk("sat_drain.m_valid", 32'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
